// File: rtl/regfile_write_arbiter.sv
// Register-file write-port sequencer: clear sweep after reset, then round-robin ALU/load writeback.
// One cycle from handshake to regWrite; both readies low during the sweep and for the losing requester.
module regfile_write_arbiter #(
  parameter int                NUM_REGS   = 32,
  parameter int                ADDR_W     = 5,
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  output logic              regWrite,
  output logic [ADDR_W-1:0] writeReg,
  output logic [DATA_W-1:0] writeData,
  output logic              init_done
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] dat;
  } wr_req_t;

  // One extra counter bit keeps the terminal compare clear of wrap-around.
  localparam logic [ADDR_W:0] SWEEP_LAST = (ADDR_W+1)'(NUM_REGS - 1);
  localparam logic [ADDR_W:0] SWEEP_INC  = (ADDR_W+1)'(1);

  state_t          state, state_nxt;
  logic [ADDR_W:0] sweep_cnt;
  logic            last_alu;
  logic            contended;
  logic            alu_xfer, mem_xfer;
  wr_req_t         win;

  always_comb begin
    state_nxt = state;
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    contended = alu_valid && mem_valid;
    case (state)
      ST_INIT: begin
        if (sweep_cnt == SWEEP_LAST) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        // On contention the source not granted last time wins.
        if (contended) begin
          alu_ready = !last_alu;
          mem_ready = last_alu;
        end else begin
          alu_ready = alu_valid;
          mem_ready = mem_valid;
        end
      end
      default: state_nxt = ST_INIT;
    endcase
    alu_xfer = alu_valid && alu_ready;
    mem_xfer = mem_valid && mem_ready;
    win      = alu_xfer ? {alu_rd, alu_data} : {mem_rd, mem_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_INIT;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep_cnt <= '0;
      last_alu  <= 1'b0;
      regWrite  <= 1'b0;
      writeReg  <= '0;
      writeData <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          regWrite  <= 1'b1;
          writeReg  <= sweep_cnt[ADDR_W-1:0];
          writeData <= INIT_VALUE;
          sweep_cnt <= sweep_cnt + SWEEP_INC;
          if (sweep_cnt == SWEEP_LAST) init_done <= 1'b1;
        end
        ST_RUN: begin
          // $0 is accepted and latched but never architecturally written.
          if (alu_xfer || mem_xfer) begin
            regWrite  <= (win.rd != '0);
            writeReg  <= win.rd;
            writeData <= win.dat;
          end else begin
            regWrite  <= 1'b0;
          end
          if (contended) last_alu <= alu_xfer;
        end
        default: regWrite <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: stimulus pushes expected writes, a monitor pops and compares.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        alu_ready;
  logic        mem_valid = 1'b0;
  logic [4:0]  mem_rd = '0;
  logic [31:0] mem_data = '0;
  logic        mem_ready;
  logic        regWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic        init_done;

  regfile_write_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData), .init_done(init_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        done;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] rf [32];
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input logic [4:0] rd, input logic [31:0] data);
    exp_t e;
    e.we = (rd != 5'd0); e.rd = rd; e.data = data; e.done = 1'b1;
    sb.push_back(e);
  endtask

  task automatic push_sweep();
    exp_t e;
    for (int i = 0; i < 32; i++) begin
      e.we = 1'b1; e.rd = 5'(i); e.data = 32'h0; e.done = (i == 31);
      sb.push_back(e);
    end
  endtask

  // One cycle: drive after the edge, check readies mid-cycle, log expected transfers.
  task automatic cyc(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                     input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                     input logic exp_ar, input logic exp_mr, input string tag);
    @(posedge clk); #1;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    @(negedge clk);
    check({tag, " alu_ready"}, {31'b0, alu_ready}, {31'b0, exp_ar});
    check({tag, " mem_ready"}, {31'b0, mem_ready}, {31'b0, exp_mr});
    if (exp_ar) push_exp(ard, ad);
    if (exp_mr) push_exp(mrd, md);
  endtask

  // Monitor: a write on the outputs (or a handshake last cycle) must match the scoreboard head.
  logic pend = 1'b0, a_wait = 1'b0, m_wait = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 1'b0; a_wait = 1'b0; m_wait = 1'b0;
    end else begin
      if (pend || regWrite) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_write actual=reg%0d/0x%0h required=no write at %0t",
                   writeReg, writeData, $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("regWrite", {31'b0, regWrite}, {31'b0, e.we});
          check("writeReg", {27'b0, writeReg}, {27'b0, e.rd});
          check("writeData", writeData, e.data);
          check("init_done", {31'b0, init_done}, {31'b0, e.done});
        end
      end
      if (regWrite) rf[writeReg] = writeData;
      if (a_wait) check("alu_valid held until ready", {31'b0, alu_valid}, 32'd1);
      if (m_wait) check("mem_valid held until ready", {31'b0, mem_valid}, 32'd1);
      if (alu_ready && mem_ready) check("single grant", 32'd2, 32'd1);
      pend   = (alu_valid && alu_ready) || (mem_valid && mem_ready);
      a_wait = init_done && alu_valid && !alu_ready;
      m_wait = init_done && mem_valid && !mem_ready;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("reset regWrite", {31'b0, regWrite}, 32'd0);
    check("reset writeReg", {27'b0, writeReg}, 32'd0);
    check("reset writeData", writeData, 32'd0);
    check("reset init_done", {31'b0, init_done}, 32'd0);

    // Sweep with an ALU request pending throughout.
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
    push_sweep();
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    check("sweep alu_ready", {31'b0, alu_ready}, 32'd0);
    for (int i = 0; i < 31; i++) cyc(1, 9, 32'h99, 0, 0, 0, 0, 0, "sweep");
    cyc(1, 9, 32'h99, 0, 0, 0, 1, 0, "first run");

    // Single ALU write, then idle.
    cyc(1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 0, "alu only");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, "idle");

    // Contention alternates, starting with ALU.
    cyc(1, 3, 32'h11, 1, 4, 32'h22, 1, 0, "rr1");
    cyc(1, 3, 32'h11, 1, 4, 32'h22, 0, 1, "rr2");
    cyc(1, 3, 32'h11, 1, 4, 32'h22, 1, 0, "rr3");
    cyc(1, 3, 32'h11, 1, 4, 32'h22, 0, 1, "rr4");
    cyc(1, 3, 32'h11, 0, 0, 0, 1, 0, "rr tail");

    // $0 load: accepted, not written.
    cyc(0, 0, 0, 1, 0, 32'hFFFFFFFF, 0, 1, "rd0");

    // Contended grant to ALU, then same-rd conflict goes MEM first.
    cyc(1, 1, 32'h1, 1, 2, 32'h2, 1, 0, "pre");
    cyc(0, 0, 0, 1, 2, 32'h2, 0, 1, "pre mem");
    cyc(1, 7, 32'hA, 1, 7, 32'hB, 0, 1, "same rd1");
    cyc(1, 7, 32'hA, 0, 0, 0, 1, 0, "same rd2");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, "idle2");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, "idle3");
    check("reg7 final", rf[7], 32'hA);

    // Reset while a load write is on the outputs.
    cyc(0, 0, 0, 1, 12, 32'h5, 0, 1, "pre reset");
    @(posedge clk); #3;
    rst_n = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd13; alu_data = 32'h6;
    sb.delete();
    #1;
    check("async regWrite", {31'b0, regWrite}, 32'd0);
    check("async init_done", {31'b0, init_done}, 32'd0);
    check("async writeReg", {27'b0, writeReg}, 32'd0);
    check("async mem_ready", {31'b0, mem_ready}, 32'd0);
    push_sweep();
    repeat (3) @(posedge clk);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    check("resweep mem_ready", {31'b0, mem_ready}, 32'd0);
    for (int i = 0; i < 31; i++) cyc(1, 13, 32'h6, 1, 12, 32'h5, 0, 0, "resweep");
    cyc(1, 13, 32'h6, 1, 12, 32'h5, 1, 0, "after reset rr");
    cyc(0, 0, 0, 1, 12, 32'h5, 0, 1, "after reset mem");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, "idle4");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, "idle5");
    check("scoreboard drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Sequences and shares the single register-file write port. After reset it runs a clear sweep that writes INIT_VALUE to every register. It then arbitrates between two writeback requesters, the ALU result path and the memory load path, using a valid/ready handshake. It drives registered regWrite/writeReg/writeData into the register file and suppresses architectural writes to $0.

Parameters:
NUM_REGS, 32, number of registers swept at init; must be 2**ADDR_W
ADDR_W, 5, register address width
DATA_W, 32, register data width
INIT_VALUE, 0, value written to each register during the clear sweep

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
alu_valid  input  1  ALU writeback request
alu_rd  input  ADDR_W  ALU destination register
alu_data  input  DATA_W  ALU result
alu_ready  output  1  ALU request accepted this cycle
mem_valid  input  1  load writeback request
mem_rd  input  ADDR_W  load destination register
mem_data  input  DATA_W  load data
mem_ready  output  1  load request accepted this cycle
regWrite  output  1  register-file write enable (registered)
writeReg  output  ADDR_W  register-file write address (registered)
writeData  output  DATA_W  register-file write data (registered)
init_done  output  1  high once the clear sweep completes (registered)

Behaviour:
- Reset (rst_n low, asynchronous): state=INIT, sweep counter=0, regWrite=0, writeReg=0, writeData=0, init_done=0, last-grant pointer=MEM (the first contended grant goes to ALU).
- alu_ready/mem_ready are combinational from state, the grant pointer and the valid inputs. Both are 0 in INIT.
- INIT: each cycle, register regWrite=1, writeReg=counter, writeData=INIT_VALUE; counter increments.
  - Register 0 is included in the sweep so the register file holds a defined $0.
  - After the cycle that writes NUM_REGS-1 (NUM_REGS cycles total), go to RUN and set init_done=1 on the same edge.
  - Counter width is ADDR_W+1 so the terminal compare does not wrap.
- RUN, grant rules:
  - Only alu_valid: alu_ready=1.
  - Only mem_valid: mem_ready=1.
  - Both: round-robin. Grant the source not granted at the last contended cycle. The pointer updates only on contended cycles.
  - Neither: no ready, and regWrite=0 next cycle.
- Handshake: a transfer occurs when valid&&ready. Requesters must hold rd/data stable while valid&&!ready. Valid may not be withdrawn before acceptance; this is a bench assertion.
- Latency: the accepted request appears on regWrite/writeReg/writeData at the next rising edge (1 cycle). Throughput is 1 write per cycle.
- rd==0: the request is accepted normally (ready asserted, grant pointer updated). On the output, regWrite=0; writeReg and writeData still load the request values.
- Same-rd conflict: both sources targeting the same rd are serialized in grant order, so the later-granted write wins in the register file. No merging.
- regWrite is 0 on any cycle without an accepted non-zero-rd transfer. writeReg/writeData hold their last values when idle.
- Reset mid-operation: any in-flight or pending request is dropped (no ready is ever given to it) and the sweep restarts from 0. init_done falls asynchronously.
- RUN is terminal until reset. There is no software-triggered re-sweep.

Test Plan:
- Release rst_n -> regWrite=1 for exactly 32 consecutive cycles with writeReg 0..31, writeData=0; init_done rises with the last sweep edge; alu_ready=mem_ready=0 throughout, even with both valids held high.
- RUN, alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF for one cycle -> alu_ready=1 that cycle; next cycle regWrite=1, writeReg=5, writeData=0xDEADBEEF; following cycle regWrite=0.
- Both valid held for 4 cycles, alu_rd=3/data=0x11, mem_rd=4/data=0x22 (each requester presents new data after acceptance) -> grants ALU, MEM, ALU, MEM; outputs alternate 3/0x11 and 4/0x22 one cycle later.
- mem_valid=1, mem_rd=0, mem_data=0xFFFFFFFF -> mem_ready=1; next cycle regWrite=0, writeReg=0.
- Both valid with rd=7 (alu 0xA, mem 0xB) after the last grant went to ALU -> MEM written first, ALU second; register 7 ends at 0xA.
- Assert rst_n low mid-transfer with mem_valid held high -> regWrite drops to 0 immediately; after release the sweep restarts at writeReg=0 and mem_ready stays 0 for 32 cycles.
